// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the control unit.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    // instruction memory side
    logic                  imemReq;
    logic [ADDR_WIDTH-1:0] imemAddr;
    logic                  imemValid;
    logic [31:0]           imemData;
    // control unit side
    logic [31:0]           instruction;
    logic [ADDR_WIDTH-1:0] instrPC;
    logic                  instrValid;
    logic                  instrReady;
    logic [31:0]           instrCount;

    modport master (
        output imemReq, imemAddr, instruction, instrPC, instrValid, instrCount,
        input  imemValid, imemData, instrReady
    );

    modport slave (
        input  imemReq, imemAddr, instruction, instrPC, instrValid, instrCount,
        output imemValid, imemData, instrReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in
// flight at most, and hands the returned word to control through a
// valid/ready holding register. Branch redirects win over everything else.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  enablePC,
    input  logic                  branch,
    input  logic [ADDR_WIDTH-1:0] branchTarget,
    fetch_unit_if.master          bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 32;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  r_discard;
    logic [DATA_W-1:0]     r_instruction;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic                  r_instr_valid;
    logic [COUNT_W-1:0]    r_instr_count;

    state_t                w_state;
    logic [ADDR_WIDTH-1:0] w_fetch_pc;
    logic                  w_discard;
    logic [DATA_W-1:0]     w_instruction;
    logic [ADDR_WIDTH-1:0] w_instr_pc;
    logic                  w_instr_valid;
    logic [COUNT_W-1:0]    w_instr_count;
    logic                  w_req;
    logic [ADDR_WIDTH-1:0] w_target;

    // Redirect target is always word aligned.
    assign w_target = {branchTarget[ADDR_WIDTH-1:2], 2'b00};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state       <= ST_ISSUE;
            r_fetch_pc    <= RESET_PC;
            r_discard     <= 1'b0;
            r_instruction <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state       <= w_state;
            r_fetch_pc    <= w_fetch_pc;
            r_discard     <= w_discard;
            r_instruction <= w_instruction;
            r_instr_pc    <= w_instr_pc;
            r_instr_valid <= w_instr_valid;
            r_instr_count <= w_instr_count;
        end
    end

    // Next-state and request logic; a branch in any state reloads the PC.
    always_comb begin
        w_state       = r_state;
        w_fetch_pc    = r_fetch_pc;
        w_discard     = r_discard;
        w_instruction = r_instruction;
        w_instr_pc    = r_instr_pc;
        w_instr_valid = r_instr_valid;
        w_instr_count = r_instr_count;
        w_req         = 1'b0;

        unique case (r_state)
            ST_ISSUE: begin
                w_req = enablePC && !branch && resetN;
                if (branch) begin
                    w_fetch_pc = w_target;
                end else if (enablePC) begin
                    w_state = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (branch) begin
                    w_fetch_pc = w_target;
                    if (bus.imemValid) begin
                        // Response arriving with the redirect is simply dropped.
                        w_discard = 1'b0;
                        w_state   = ST_ISSUE;
                    end else begin
                        w_discard = 1'b1;
                    end
                end else if (bus.imemValid) begin
                    if (r_discard) begin
                        w_discard = 1'b0;
                        w_state   = ST_ISSUE;
                    end else begin
                        w_instruction = bus.imemData;
                        w_instr_pc    = r_fetch_pc;
                        w_instr_valid = 1'b1;
                        w_state       = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (branch) begin
                    // Redirect cancels the held word; a same-cycle ready is void.
                    w_fetch_pc    = w_target;
                    w_instr_valid = 1'b0;
                    w_state       = ST_ISSUE;
                end else if (bus.instrReady) begin
                    w_fetch_pc    = r_fetch_pc + ADDR_WIDTH'(4);
                    w_instr_valid = 1'b0;
                    w_instr_count = r_instr_count + COUNT_W'(1);
                    w_state       = ST_ISSUE;
                end
            end

            default: begin
                w_state = ST_ISSUE;
            end
        endcase
    end

    assign bus.imemReq     = w_req;
    assign bus.imemAddr    = r_fetch_pc;
    assign bus.instruction = r_instruction;
    assign bus.instrPC     = r_instr_pc;
    assign bus.instrValid  = r_instr_valid;
    assign bus.instrCount  = r_instr_count;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the Lapido processor. Holds the program counter, issues one word read at a time to instruction memory, and presents the returned 32-bit word plus its PC to the control unit through a valid/ready register. Sits directly upstream of control; takes `branch`/`branchTarget` back from the execute path and `enablePC` as the global stall.

## Interface

Parameters:
- `ADDR_WIDTH`, 32, width of PC and instruction-memory address.
- `RESET_PC`, 0, PC loaded on reset; multiple of 4.

Ports:
- `clock`  in  1  single clock, all state updates on rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `enablePC`  in  1  1 = fetch may issue; 0 = no new request issued (stall).
- `branch`  in  1  one-cycle redirect pulse.
- `branchTarget`  in  ADDR_WIDTH  redirect address; bits [1:0] ignored (forced 0).
- `imemReq`  out  1  one-cycle read request pulse.
- `imemAddr`  out  ADDR_WIDTH  address for `imemReq`; equals current fetch PC.
- `imemValid`  in  1  read data valid, ≥1 cycle after `imemReq`.
- `imemData`  in  32  read data, sampled when `imemValid`.
- `instruction`  out  32  registered instruction to control.
- `instrPC`  out  ADDR_WIDTH  address of `instruction`.
- `instrValid`  out  1  `instruction` holds a live word.
- `instrReady`  in  1  control consumes `instruction` this cycle.
- `instrCount`  out  32  number of instructions accepted since reset.

## Operation

- Registers: `fetchPC`, state, `discard` flag, `instruction`, `instrPC`, `instrValid`, `instrCount`.
- Reset (`resetN`=0 at edge): `fetchPC`=RESET_PC, state=ISSUE, `discard`=0, `instruction`=0, `instrPC`=0, `instrValid`=0, `instrCount`=0. `imemReq`=0 while `resetN`=0. Reset mid-WAIT abandons the request; instruction memory shares the same reset, so no stale response follows.
- States:
  - ISSUE: `imemReq` = `enablePC` & !`branch` (combinational); `imemAddr`=`fetchPC`. If request issued -> WAIT. Otherwise stay.
  - WAIT: on `imemValid`: if `discard`, clear it -> ISSUE; else `instruction`<=`imemData`, `instrPC`<=`fetchPC`, `instrValid`<=1 -> HOLD. No new request in WAIT (one outstanding max).
  - HOLD: `instruction` stable. On `instrReady`: `instrValid`<=0, `fetchPC`<=`fetchPC`+4, `instrCount`++ -> ISSUE.
- `imemValid` outside WAIT ignored.
- Branch (highest priority, any state): `fetchPC`<={`branchTarget`[ADDR_WIDTH-1:2],2'b00}.
  - ISSUE: no request that cycle; stay ISSUE.
  - WAIT: set `discard`; stay WAIT (if `imemValid` same cycle, word dropped, `discard` not set, -> ISSUE).
  - HOLD: `instrValid`<=0 -> ISSUE; `instrReady` same cycle is ignored (no PC increment, no count).
- `enablePC`=0 only blocks issuing; outstanding response is still captured, HOLD still accepts `instrReady`.
- PC and `instrCount` wrap modulo 2^width silently.

## Timing

- Cycle 0 ISSUE (`imemReq`=1), cycle 1 `imemValid` (best case), cycle 2 `instrValid`=1, earliest `instrReady` accept cycle 2, next `imemReq` cycle 3.
- Throughput with 1-cycle memory and `instrReady` tied high: one instruction per 3 cycles.
- Redirect penalty: branch at cycle N -> first `imemReq` to target at N+1 (from ISSUE/HOLD) or the cycle after the discarded response retires.
- `instruction`/`instrPC` change only on entry to HOLD.

## Test plan

- Reset, `enablePC`=1, memory returns `0x20000000+addr` with 1-cycle latency, `instrReady`=1 -> `imemAddr` 0,4,8; `instrPC` 0,4,8 with matching data every 3 cycles; `instrCount`=3 after 3rd accept.
- `instrReady`=0 for 5 cycles in HOLD -> `instruction` stable, no `imemReq`, `instrCount` unchanged; release -> next `imemAddr`=`instrPC`+4.
- Branch to `0x103` during WAIT, memory latency 3 -> returned word dropped, `instrValid` stays 0, next `imemAddr`=0x100.
- Branch during HOLD with `instrReady`=1 same cycle -> `instrValid` drops, `instrCount` unchanged, next `imemAddr`=target.
- `enablePC`=0 in ISSUE 4 cycles -> no `imemReq`; `enablePC`=0 in WAIT -> response still captured into HOLD.
- `resetN`=0 while in WAIT at PC 0x40 -> next cycle all outputs at reset values, first `imemAddr`=RESET_PC.
